// File: rtl/legv8_control_unit.sv
// ---------------------------------------------------------------------------
// legv8_control_unit
//
// Multi-cycle LEGv8 control unit. It latches the ROM word into IR during
// FETCH, decodes IR in EX0 (and EX1 for LDUR), and drives every datapath
// control field plus the immediate constant. An unrecognised opcode parks
// the FSM in a sticky HALT state that only reset can leave.
//
// Optional feature: define CU_BCOND_EN to decode B.cond in EX0. When it is
// not defined, B.cond is treated as an unrecognised opcode and halts.
//
// Ports:
//   clock        in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-low
//   instruction  in  32   ROM word at the current PC
//   status       in   5   [4:1] registered {V,C,N,Z}, [0] live ALU zero
//   control_word out 30   {EN_PC,EN_RAM,EN_ALU,PCsel,Bsel,SL,WM,WR,PS,FS,SB,SA,DA}
//   constant     out 64   immediate derived from IR
//   halted       out  1   high while in HALT
// ---------------------------------------------------------------------------
module legv8_control_unit #(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [4:0]  status,
    output logic [29:0] control_word,
    output logic [63:0] constant,
    output logic        halted
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EX0, S_EX1, S_HALT} state_t;

    localparam logic [4:0] FS_AND   = 5'b00000;
    localparam logic [4:0] FS_ORR   = 5'b00100;
    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_SUB   = 5'b01011;
    localparam logic [4:0] FS_PASSA = 5'b11000;
    localparam logic [4:0] FS_PASSB = 5'b10100;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_ir;

    logic [4:0]  w_rd, w_rn, w_rm;
    logic [63:0] w_imm12, w_imm9, w_imm19, w_imm26, w_movz;

    assign w_rd    = r_ir[4:0];
    assign w_rn    = r_ir[9:5];
    assign w_rm    = r_ir[20:16];
    assign w_imm12 = {52'd0, r_ir[21:10]};
    assign w_imm9  = {{55{r_ir[20]}}, r_ir[20:12]};
    assign w_imm19 = {{45{r_ir[23]}}, r_ir[23:5]};
    assign w_imm26 = {{38{r_ir[25]}}, r_ir[25:0]};
    // MOVZ: imm16 placed at 16*hw, i.e. shift by {hw, 4'b0}
    assign w_movz  = {48'd0, r_ir[20:5]} << {r_ir[22:21], 4'b0000};

`ifdef CU_BCOND_EN
    // Condition codes evaluated on {V,C,N,Z}; odd codes invert the base
    // test, except 4'hF which behaves like AL.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] vcnz);
        logic v, c, n, z, base;
        {v, c, n, z} = vcnz;
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (cond[0] && (cond != 4'hF)) ? ~base : base;
    endfunction
`else
    logic w_unused_status;
    assign w_unused_status = ^status[4:1];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RESET_STATE_FETCH ? S_FETCH : S_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) r_ir <= instruction;
        end
    end

    // Arithmetic/logic group: register and immediate forms share one path.
    logic       w_alu_op, w_alu_imm, w_alu_sl;
    logic [4:0] w_alu_fs;

    always_comb begin
        w_alu_op  = 1'b1;
        w_alu_imm = 1'b0;
        w_alu_sl  = 1'b0;
        w_alu_fs  = FS_ADD;
        casez (r_ir[31:21])
            11'b10001011000: w_alu_fs = FS_ADD;                         // ADD
            11'b11001011000: w_alu_fs = FS_SUB;                         // SUB
            11'b10001010000: w_alu_fs = FS_AND;                         // AND
            11'b10101010000: w_alu_fs = FS_ORR;                         // ORR
            11'b10101011000: w_alu_sl = 1'b1;                           // ADDS
            11'b11101011000: begin w_alu_fs = FS_SUB; w_alu_sl = 1'b1; end // SUBS
            11'b1001000100?: w_alu_imm = 1'b1;                          // ADDI
            11'b1101000100?: begin w_alu_fs = FS_SUB; w_alu_imm = 1'b1; end // SUBI
            11'b1001001000?: begin w_alu_fs = FS_AND; w_alu_imm = 1'b1; end // ANDI
            11'b1011001000?: begin w_alu_fs = FS_ORR; w_alu_imm = 1'b1; end // ORRI
            default:         w_alu_op = 1'b0;
        endcase
    end

    logic [4:0]  w_da, w_sa, w_sb, w_fs;
    logic [1:0]  w_ps;
    logic        w_wr, w_wm, w_sl, w_bsel, w_en_alu, w_en_ram;
    logic [63:0] w_const;

    always_comb begin
        w_next_state = r_state;
        w_da     = '0;
        w_sa     = '0;
        w_sb     = '0;
        w_fs     = FS_AND;
        w_ps     = PS_HOLD;
        w_wr     = 1'b0;
        w_wm     = 1'b0;
        w_sl     = 1'b0;
        w_bsel   = 1'b0;
        w_en_alu = 1'b0;
        w_en_ram = 1'b0;
        w_const  = '0;
        case (r_state)
            S_IDLE:  w_next_state = S_FETCH;
            S_FETCH: w_next_state = S_EX0;
            S_EX0: begin
                w_next_state = S_FETCH;
                if (w_alu_op) begin
                    w_da     = w_rd;
                    w_sa     = w_rn;
                    w_sb     = w_alu_imm ? 5'd0 : w_rm;
                    w_fs     = w_alu_fs;
                    w_sl     = w_alu_sl;
                    w_bsel   = w_alu_imm;
                    w_wr     = 1'b1;
                    w_en_alu = 1'b1;
                    w_ps     = PS_INC;
                    w_const  = w_alu_imm ? w_imm12 : 64'd0;
                end else begin
                    casez (r_ir[31:21])
                        11'b110100101??: begin                  // MOVZ, result via ALU pass-B
                            w_da = w_rd; w_fs = FS_PASSB; w_bsel = 1'b1;
                            w_wr = 1'b1; w_en_alu = 1'b1; w_ps = PS_INC;
                            w_const = w_movz;
                        end
                        11'b11111000000: begin                  // STUR
                            w_sa = w_rn; w_sb = w_rd; w_bsel = 1'b1; w_fs = FS_ADD;
                            w_wm = 1'b1; w_ps = PS_INC; w_const = w_imm9;
                        end
                        11'b11111000010: begin                  // LDUR address phase
                            w_sa = w_rn; w_bsel = 1'b1; w_fs = FS_ADD;
                            w_const = w_imm9; w_next_state = S_EX1;
                        end
                        11'b1011010????: begin                  // CBZ (IR[24]=0) / CBNZ (IR[24]=1)
                            w_sa = w_rd; w_sb = 5'd31; w_fs = FS_PASSA; w_const = w_imm19;
                            w_ps = (status[0] ^ r_ir[24]) ? PS_BR : PS_INC;
                        end
                        11'b000101?????: begin                  // B
                            w_ps = PS_BR; w_const = w_imm26;
                        end
`ifdef CU_BCOND_EN
                        11'b01010100???: begin                  // B.cond
                            w_ps = cond_holds(r_ir[3:0], status[4:1]) ? PS_BR : PS_INC;
                            w_const = w_imm19;
                        end
`endif
                        default: w_next_state = S_HALT;
                    endcase
                end
            end
            S_EX1: begin                                        // LDUR data phase
                w_sa = w_rn; w_bsel = 1'b1; w_fs = FS_ADD; w_const = w_imm9;
                w_en_ram = 1'b1; w_wr = 1'b1; w_da = w_rd; w_ps = PS_INC;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_HALT;
        endcase
    end

    // PS alone steers the PC, so PCsel and EN_PC stay low.
    assign control_word = {1'b0, w_en_ram, w_en_alu, 1'b0, w_bsel, w_sl, w_wm, w_wr,
                           w_ps, w_fs, w_sb, w_sa, w_da};
    assign constant     = w_const;
    assign halted       = (r_state == S_HALT);

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multi-cycle LEGv8 control unit that produces the control word and constant consumed by the datapath.
- Each cycle it latches the instruction from the instruction ROM, decodes it, and sequences the datapath through fetch, execute and writeback.
- It reads back the datapath status flags for conditional branches.
- It sits between the program ROM/program counter and the datapath, and is the only source of every datapath control field.

Parameters:
- RESET_STATE_FETCH, 1, 1 = leave reset directly into FETCH; 0 = insert one idle cycle (state IDLE) first.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- instruction  input  32  instruction word from the ROM at the current PC; combinational.
- status  input  5  status[4:1] = registered {V,C,N,Z}; status[0] = live ALU zero.
- control_word  output  30  DA[4:0], SA[9:5], SB[14:10], FS[19:15], PS[21:20], WR[22], WM[23], SL[24], Bsel[25], PCsel[26], EN_ALU[27], EN_RAM[28], EN_PC[29].
- constant  output  64  immediate for the datapath, derived from IR.
- halted  output  1  high while in HALT.

Behaviour:
- States: IDLE, FETCH, EX0, EX1, HALT. Instruction register IR is 32 bits.
- Reset (async, reset=0):
  - state = FETCH, or IDLE when RESET_STATE_FETCH=0; IR = 0.
  - Outputs during reset: control_word = 0 and constant = 0, which gives PS=00 (hold) and no writes.
- IDLE -> FETCH unconditionally.
- FETCH:
  - IR <= instruction. control_word all zero, so PS=00 and the PC holds.
  - Next state EX0.
- EX0 decodes IR[31:21]. control_word and constant are combinational from state and IR.
  - R-type ADD/SUB/AND/ORR/ADDS/SUBS:
    - SA=Rn, SB=Rm, DA=Rd, Bsel=0, WR=1, EN_ALU=1, PS=01.
    - SL=1 only for ADDS/SUBS.
  - ADDI/SUBI/ANDI/ORRI: as R-type with Bsel=1; constant = zero-extended imm12 (IR[21:10]).
  - MOVZ:
    - FS = pass-B, Bsel=1, DA=Rd, WR=1, PS=01.
    - constant = imm16 << (16*hw), with hw = IR[22:21].
  - STUR:
    - SA=Rn, SB=Rt, Bsel=1, FS=ADD, WM=1, WR=0, PS=01.
    - constant = sign-extended imm9 (IR[20:12]).
  - LDUR in EX0: address phase; SA=Rn, Bsel=1, FS=ADD, WR=0, PS=00. Next state EX1.
  - LDUR in EX1: same address fields plus EN_RAM=1, WR=1, DA=Rt, PS=01. Next state FETCH.
  - CBZ/CBNZ:
    - SA=Rt, SB=31, FS=pass-A, WR=0. constant = sign-extended imm19.
    - PS=10 if status[0]==1 for CBZ, or status[0]==0 for CBNZ; otherwise PS=01.
  - B: PS=10, constant = sign-extended imm26.
  - Unrecognised opcode: no writes, PS=00, next state HALT.
  - Every legal single-cycle instruction returns to FETCH after EX0.
- FS encoding is {fn[2:0], invB, Cin}:
  - AND=00000, ORR=00100, ADD=01000, SUB=01011, pass-A=11000, pass-B=10100.
- PS encoding: 00 hold, 01 PC+4, 10 PC+(constant<<2), 11 unused (never driven).
- The PC changes only in the final execute cycle of each instruction. Instructions take 2 cycles, LDUR takes 3.
- HALT: sticky. control_word = 0, halted=1; leaves only via reset.
- Register 31 (XZR) is encoded as-is; the regfile handles it.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after reset deasserts, because the FSM restarts at FETCH/IDLE.

Optional Feature:
- Macro CU_BCOND_EN.
- Defined: B.cond (IR[31:24]=01010100) is decoded in EX0. cond = IR[3:0] is evaluated on status[4:1]: EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Taken gives PS=10 with constant = sign-extended imm19 (IR[23:5]); not taken gives PS=01.
- Not defined: B.cond is an unrecognised opcode and goes to HALT.

Test Plan:
- Reset low mid-EX0 -> control_word=0 and constant=0 within the same cycle; after release, FETCH then EX0 of the current ROM word.
- ADD X3,X1,X2 (0x8B020023) -> EX0: DA=3, SA=1, SB=2, FS=01000, WR=1, PS=01, Bsel=0; back to FETCH next cycle.
- LDUR X5,[X2,#8] (0xF8408045) -> EX0: PS=00, WR=0, constant=8; EX1: EN_RAM=1, WR=1, DA=5, PS=01; total 3 cycles.
- CBZ X4,#-2 (0xB4FFFFC4):
  - with status[0]=1 -> PS=10, constant=0xFFFFFFFFFFFFFFFE;
  - with status[0]=0 -> PS=01.
- MOVZ X7,#0x1234,LSL 16 (0xD2A24687) -> constant=0x0000000012340000, FS=10100, DA=7, WR=1.
- Opcode 0x00000000 -> HALT, halted=1, control_word stays 0 for 10 cycles; with CU_BCOND_EN, B.EQ with status[1]=1 -> PS=10.
